// File: rtl/pwm_ramp_ctrl.sv
// ----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Soft-start / soft-stop sequencer for one PWM channel. It moves the channel's
// on-time from its present value to a commanded target in fixed steps. Steps
// are applied only on PWM period boundaries, so a period is never changed
// part-way through. All times are in 20 ns clock units.
//
// Ports
//   clk         in   system clock (50 MHz)
//   reset       in   asynchronous, active-low reset
//   start       in   one-cycle pulse: latch target_on/step/ramp_div, begin ramp
//   abort       in   one-cycle pulse: force on-time to 0, go idle
//   target_on   in   requested final on-time            [W_TIME]
//   step        in   on-time change per update (0 -> 1)  [W_STEP]
//   ramp_div    in   period_end pulses per update (0 -> 1) [W_DIV]
//   period_end  in   one-cycle pulse at each PWM period reload
//   t_on_out    out  current commanded on-time (registered) [W_TIME]
//   t_on_load   out  one-cycle strobe: t_on_out changed this cycle
//   busy        out  high while ramping up or down
//   done        out  one-cycle pulse: target reached
// ----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
    parameter int W_TIME = 32,
    parameter int W_STEP = 16,
    parameter int W_DIV  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [W_TIME-1:0] target_on,
    input  logic [W_STEP-1:0] step,
    input  logic [W_DIV-1:0]  ramp_div,
    input  logic              period_end,
    output logic [W_TIME-1:0] t_on_out,
    output logic              t_on_load,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_e;

    state_e            state_q,   state_d;
    logic [W_TIME-1:0] cur_q,     cur_d;
    logic [W_TIME-1:0] tgt_q,     tgt_d;
    logic [W_STEP-1:0] stp_q,     stp_d;
    logic [W_DIV-1:0]  div_rld_q, div_rld_d;
    logic [W_DIV-1:0]  div_cnt_q, div_cnt_d;
    logic              load_q,    load_d;
    logic              done_q,    done_d;

    // Zero-substituted versions of the command inputs.
    logic [W_STEP-1:0] step_eff;
    logic [W_DIV-1:0]  div_eff;

    assign step_eff = (step == '0)     ? W_STEP'(1) : step;
    assign div_eff  = (ramp_div == '0) ? W_DIV'(1)  : ramp_div;

    // ------------------------------------------------------------------
    // Update arithmetic. Both directions are evaluated one bit wider than
    // the on-time so that carry out (up) and borrow (down) are visible and
    // the result can be clamped to the target instead of wrapping.
    // ------------------------------------------------------------------
    logic [W_TIME:0]   stp_ext;
    logic [W_TIME:0]   sum_ext;
    logic [W_TIME:0]   diff_ext;
    logic [W_TIME-1:0] up_next;
    logic [W_TIME-1:0] down_next;
    logic [W_TIME-1:0] upd_next;

    assign stp_ext  = {{(W_TIME + 1 - W_STEP){1'b0}}, stp_q};
    assign sum_ext  = {1'b0, cur_q} + stp_ext;
    assign diff_ext = {1'b0, cur_q} - stp_ext;

    assign up_next   = (sum_ext >= {1'b0, tgt_q}) ? tgt_q : sum_ext[W_TIME-1:0];
    // diff_ext[W_TIME] set means the subtraction borrowed (went below zero).
    assign down_next = (diff_ext[W_TIME] || (diff_ext[W_TIME-1:0] <= tgt_q))
                       ? tgt_q : diff_ext[W_TIME-1:0];

    assign upd_next  = (state_q == RAMP_UP) ? up_next : down_next;

    // ------------------------------------------------------------------
    // Next-state logic. Priority: abort > start > period_end; a
    // period_end arriving with start or abort is simply not looked at.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        stp_d     = stp_q;
        div_rld_d = div_rld_q;
        div_cnt_d = div_cnt_q;
        load_d    = 1'b0;
        done_d    = 1'b0;

        if (abort) begin
            // Load strobe fires even if the on-time was already zero so the
            // channel always sees the forced value.
            cur_d   = '0;
            load_d  = 1'b1;
            state_d = IDLE;
        end else if (start) begin
            tgt_d     = target_on;
            stp_d     = step_eff;
            div_rld_d = div_eff;
            div_cnt_d = div_eff;
            if (target_on > cur_q) begin
                state_d = RAMP_UP;
            end else if (target_on < cur_q) begin
                state_d = RAMP_DOWN;
            end else begin
                // Already there: report completion without touching t_on_out.
                state_d = HOLD;
                done_d  = 1'b1;
            end
        end else if (period_end &&
                     ((state_q == RAMP_UP) || (state_q == RAMP_DOWN))) begin
            if (div_cnt_q == W_DIV'(1)) begin
                div_cnt_d = div_rld_q;
                cur_d     = upd_next;
                load_d    = 1'b1;
                if (upd_next == tgt_q) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q - W_DIV'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            stp_q     <= W_STEP'(1);
            div_rld_q <= W_DIV'(1);
            div_cnt_q <= W_DIV'(1);
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            stp_q     <= stp_d;
            div_rld_q <= div_rld_d;
            div_cnt_q <= div_cnt_d;
            load_q    <= load_d;
            done_q    <= done_d;
        end
    end

    assign t_on_out  = cur_q;
    assign t_on_load = load_q;
    assign done      = done_q;
    assign busy      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//
// Self-checking bench for pwm_ramp_ctrl. A behavioural model (plain integer
// arithmetic, a period counter since the last start) predicts t_on_out,
// t_on_load, busy and done every cycle. Directed sequences cover the ramp
// cases of interest, followed by randomized traffic. A second, narrower
// instance exercises the no-wrap clamp at the top of the on-time range.
// ----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int W_TIME = 32;
    localparam int W_STEP = 16;
    localparam int W_DIV  = 8;
    localparam int NW     = 20;   // on-time width of the narrow instance

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [W_TIME-1:0] target_on = '0;
    logic [W_STEP-1:0] step = '0;
    logic [W_DIV-1:0]  ramp_div = '0;
    logic              period_end = 1'b0;
    logic [W_TIME-1:0] t_on_out;
    logic              t_on_load;
    logic              busy;
    logic              done;

    logic              n_start = 1'b0;
    logic              n_abort = 1'b0;
    logic [NW-1:0]     n_target = '0;
    logic [W_STEP-1:0] n_step = '0;
    logic [W_DIV-1:0]  n_div = '0;
    logic              n_pe = 1'b0;
    logic [NW-1:0]     n_t_on_out;
    logic              n_t_on_load;
    logic              n_busy;
    logic              n_done;

    always #10 clk = ~clk;

    pwm_ramp_ctrl #(.W_TIME(W_TIME), .W_STEP(W_STEP), .W_DIV(W_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .target_on  (target_on),
        .step       (step),
        .ramp_div   (ramp_div),
        .period_end (period_end),
        .t_on_out   (t_on_out),
        .t_on_load  (t_on_load),
        .busy       (busy),
        .done       (done)
    );

    pwm_ramp_ctrl #(.W_TIME(NW), .W_STEP(W_STEP), .W_DIV(W_DIV)) dut_n (
        .clk        (clk),
        .reset      (reset),
        .start      (n_start),
        .abort      (n_abort),
        .target_on  (n_target),
        .step       (n_step),
        .ramp_div   (n_div),
        .period_end (n_pe),
        .t_on_out   (n_t_on_out),
        .t_on_load  (n_t_on_load),
        .busy       (n_busy),
        .done       (n_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                      tag, obs, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    longint m_cur, m_tgt, m_stp, m_div, m_periods;
    bit     m_ramping, m_load, m_done;

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_stp = 1; m_div = 1; m_periods = 0;
        m_ramping = 0; m_load = 0; m_done = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit pe,
                              input longint tgt, input longint st,
                              input longint dv);
        m_load = 0;
        m_done = 0;
        if (a) begin
            m_cur = 0; m_load = 1; m_ramping = 0;
        end else if (s) begin
            m_tgt = tgt;
            m_stp = (st == 0) ? 1 : st;
            m_div = (dv == 0) ? 1 : dv;
            m_periods = 0;
            if (tgt == m_cur) begin
                m_ramping = 0; m_done = 1;
            end else begin
                m_ramping = 1;
            end
        end else if (pe && m_ramping) begin
            m_periods++;
            if (m_periods % m_div == 0) begin
                if (m_cur < m_tgt)
                    m_cur = (m_cur + m_stp > m_tgt) ? m_tgt : m_cur + m_stp;
                else
                    m_cur = (m_cur - m_stp < m_tgt) ? m_tgt : m_cur - m_stp;
                m_load = 1;
                if (m_cur == m_tgt) begin
                    m_ramping = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".t_on_out"},  {32'b0, t_on_out}, m_cur);
        check({where, ".t_on_load"}, {63'b0, t_on_load}, {63'b0, m_load});
        check({where, ".busy"},      {63'b0, busy},      {63'b0, m_ramping});
        check({where, ".done"},      {63'b0, done},      {63'b0, m_done});
    endtask

    // One clock of stimulus on the main instance, checked against the model.
    task automatic tick(input string where, input bit s, input bit a,
                        input bit pe, input logic [W_TIME-1:0] tgt,
                        input logic [W_STEP-1:0] st,
                        input logic [W_DIV-1:0] dv);
        @(negedge clk);
        start = s; abort = a; period_end = pe;
        target_on = tgt; step = st; ramp_div = dv;
        @(posedge clk);
        model_step(s, a, pe, longint'(tgt), longint'(st), longint'(dv));
        #1;
        check_outputs(where);
        start = 0; abort = 0; period_end = 0;
    endtask

    task automatic idle(input string where);
        tick(where, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic pe_tick(input string where);
        tick(where, 0, 0, 1, '0, '0, '0);
    endtask

    // Assert reset asynchronously mid-cycle; outputs must clear at once.
    task automatic apply_reset(input string where);
        @(negedge clk);
        #3;
        reset = 0;
        #1;
        check({where, ".rst_t_on_out"},  {32'b0, t_on_out}, 64'd0);
        check({where, ".rst_t_on_load"}, {63'b0, t_on_load}, 64'd0);
        check({where, ".rst_busy"},      {63'b0, busy},      64'd0);
        check({where, ".rst_done"},      {63'b0, done},      64'd0);
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic n_tick(input bit s, input bit pe, input logic [NW-1:0] tgt,
                          input logic [W_STEP-1:0] st,
                          input logic [W_DIV-1:0] dv);
        @(negedge clk);
        n_start = s; n_pe = pe; n_target = tgt; n_step = st; n_div = dv;
        @(posedge clk);
        #1;
        n_start = 0; n_pe = 0;
    endtask

    initial begin
        bit seen;
        int loads;

        model_reset();
        #25;
        check("reset.t_on_out", {32'b0, t_on_out}, 64'd0);
        check("reset.busy",     {63'b0, busy},     64'd0);
        @(negedge clk);
        reset = 1;
        idle("post_reset");

        // Ramp up 0 -> 10 by 3, one update per period: 3,6,9,10.
        tick("up.start", 1, 0, 0, 32'd10, 16'd3, 8'd1);
        for (int i = 0; i < 5; i++) begin
            pe_tick("up.pe");
            idle("up.gap");
        end
        check("up.final", {32'b0, t_on_out}, 64'd10);
        check("up.hold_busy", {63'b0, busy}, 64'd0);

        // Target equal to current value: done only, no load, no busy.
        tick("eq.start", 1, 0, 0, 32'd10, 16'd5, 8'd1);
        check("eq.done", {63'b0, done}, 64'd1);
        check("eq.no_load", {63'b0, t_on_load}, 64'd0);
        idle("eq.after");

        // Ramp down 10 -> 0 by 4, every 2nd period: 6,2,0.
        tick("down.start", 1, 0, 0, 32'd0, 16'd4, 8'd2);
        loads = 0;
        for (int i = 0; i < 8; i++) begin
            pe_tick("down.pe");
            if (t_on_load) loads++;
        end
        check("down.loads", 64'(loads), 64'd3);
        check("down.final", {32'b0, t_on_out}, 64'd0);

        // Abort coincident with period_end mid-ramp (cur=6 toward 10).
        tick("abort.start", 1, 0, 0, 32'd10, 16'd3, 8'd1);
        pe_tick("abort.pe1");
        pe_tick("abort.pe2");
        check("abort.pre", {32'b0, t_on_out}, 64'd6);
        tick("abort.hit", 0, 1, 1, '0, '0, '0);
        check("abort.load", {63'b0, t_on_load}, 64'd1);
        check("abort.no_done", {63'b0, done}, 64'd0);
        idle("abort.after");
        pe_tick("abort.idle_pe");

        // Zero step and zero divider behave as 1; reset after first update.
        tick("zero.start", 1, 0, 0, 32'd2, 16'd0, 8'd0);
        pe_tick("zero.pe1");
        check("zero.first", {32'b0, t_on_out}, 64'd1);
        apply_reset("zero");
        idle("zero.after_reset");
        pe_tick("zero.no_resume");

        // Run-to-completion with zero step/div: 1, 2, done.
        tick("zero2.start", 1, 0, 0, 32'd2, 16'd0, 8'd0);
        pe_tick("zero2.pe1");
        pe_tick("zero2.pe2");
        check("zero2.final", {32'b0, t_on_out}, 64'd2);

        // Narrow instance: ramp near the top of range, then a step that
        // would overflow must clamp to the target.
        n_tick(1, 0, 20'hF0005, 16'hFFFF, 8'd1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            n_tick(0, 1, '0, '0, '0);
            if (n_done) seen = 1;
        end
        check("wrap.reach_done", {63'b0, seen}, 64'd1);
        check("wrap.reach_val", {44'b0, n_t_on_out}, 64'hF0005);
        n_tick(1, 0, 20'hFFFFF, 16'hFFFF, 8'd1);
        n_tick(0, 1, '0, '0, '0);
        check("wrap.val",  {44'b0, n_t_on_out}, 64'hFFFFF);
        check("wrap.load", {63'b0, n_t_on_load}, 64'd1);
        check("wrap.done", {63'b0, n_done}, 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit s, a, pe;
            logic [W_TIME-1:0] tg;
            s  = ($urandom_range(0, 19) == 0);
            a  = ($urandom_range(0, 59) == 0);
            pe = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) tg = $urandom;
            else tg = W_TIME'($urandom_range(0, 300));
            tick("rand", s, a, pe, tg, W_STEP'($urandom_range(0, 40)),
                 W_DIV'($urandom_range(0, 3)));
            if (i == 1500) apply_reset("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
